// File: rtl/pic_init_sequencer_pkg.sv
// Shared types and constants for the 8259-style PIC init sequencer: bus-writer
// FSM states, init word steps, fixed ICW bits and the word encoder.
package pic_init_sequencer_pkg;

    localparam int unsigned WrLowDefault = 2;
    localparam int unsigned WrGapDefault = 2;

    // D4 marks a byte at a0=0 as ICW1; D0 of ICW4 selects 8086 mode.
    localparam logic [7:0] Icw1Fixed = 8'h10;
    localparam logic [7:0] Icw4Fixed = 8'h01;

    typedef enum logic [2:0] {
        WrIdle,
        WrSetup,
        WrStrobe,
        WrHold,
        WrGap
    } wr_state_e;

    typedef enum logic [2:0] {
        StepIcw1,
        StepIcw2,
        StepIcw3,
        StepIcw4,
        StepOcw1
    } step_e;

    typedef struct packed {
        logic       single;
        logic       level;
        logic       ic4;
        logic [4:0] vector;
        logic [7:0] cascade;
        logic       aeoi;
        logic [7:0] mask;
    } cfg_t;

    function automatic step_e next_step(step_e step, cfg_t cfg);
        step_e nxt;
        case (step)
            StepIcw1: nxt = StepIcw2;
            StepIcw2: nxt = cfg.single ? (cfg.ic4 ? StepIcw4 : StepOcw1) : StepIcw3;
            StepIcw3: nxt = cfg.ic4 ? StepIcw4 : StepOcw1;
            default:  nxt = StepOcw1;
        endcase
        return nxt;
    endfunction

    // Returns {a0, D7..D0} for one init step.
    function automatic logic [8:0] init_word(step_e step, cfg_t cfg);
        logic [8:0] word;
        case (step)
            StepIcw1: word = {1'b0, Icw1Fixed | {4'b0000, cfg.level, 1'b0, cfg.single, cfg.ic4}};
            StepIcw2: word = {1'b1, cfg.vector, 3'b000};
            StepIcw3: word = {1'b1, cfg.cascade};
            StepIcw4: word = {1'b1, Icw4Fixed | {6'b000000, cfg.aeoi, 1'b0}};
            default:  word = {1'b1, cfg.mask};
        endcase
        return word;
    endfunction

endpackage

// File: rtl/pic_init_sequencer_bus_writer.sv
// Single PIC bus write: SETUP, STROBE (WR_LOW cycles), HOLD, GAP (WR_GAP cycles).
// done_o marks the last GAP cycle, where start_i chains the next write with no idle.
module pic_bus_writer
    import pic_init_sequencer_pkg::*;
#(
    parameter int unsigned WR_LOW = WrLowDefault,
    parameter int unsigned WR_GAP = WrGapDefault
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       a0_i,
    input  logic [7:0] data_i,
    output logic       idle_o,
    output logic       done_o,
    output logic       wr_neg_o,
    output logic       a0_o,
    output logic [7:0] data_o,
    output logic       data_oe_o
);

    localparam logic [3:0] LowLast = 4'(WR_LOW - 1);
    localparam logic [3:0] GapLast = 4'(WR_GAP - 1);

    wr_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a0_q, a0_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WrIdle;
            cnt_q   <= '0;
            a0_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a0_q    <= a0_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a0_d    = a0_q;
        data_d  = data_q;
        done_o  = 1'b0;
        unique case (state_q)
            WrIdle: begin
                if (start_i) begin
                    state_d = WrSetup;
                    a0_d    = a0_i;
                    data_d  = data_i;
                end
            end
            WrSetup: begin
                state_d = WrStrobe;
                cnt_d   = '0;
            end
            WrStrobe: begin
                if (cnt_q == LowLast) begin
                    state_d = WrHold;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WrHold: begin
                state_d = WrGap;
                cnt_d   = '0;
            end
            WrGap: begin
                if (cnt_q == GapLast) begin
                    done_o = 1'b1;
                    if (start_i) begin
                        state_d = WrSetup;
                        a0_d    = a0_i;
                        data_d  = data_i;
                    end else begin
                        state_d = WrIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = WrIdle;
        endcase
    end

    always_comb begin
        idle_o    = (state_q == WrIdle);
        data_oe_o = (state_q == WrSetup) || (state_q == WrStrobe) || (state_q == WrHold);
        wr_neg_o  = (state_q != WrStrobe);
        a0_o      = data_oe_o ? a0_q : 1'b0;
        data_o    = data_oe_o ? data_q : 8'h00;
    end

endmodule

// File: rtl/pic_init_sequencer.sv
// Sequences the PIC init words (ICW1..ICW4, OCW1) through the bus writer and
// then accepts single runtime OCW writes.
module pic_init_sequencer
    import pic_init_sequencer_pkg::*;
#(
    parameter int unsigned WR_LOW = WrLowDefault,
    parameter int unsigned WR_GAP = WrGapDefault
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_start,
    input  logic       cfg_single,
    input  logic       cfg_level,
    input  logic       cfg_ic4,
    input  logic [4:0] cfg_vector,
    input  logic [7:0] cfg_cascade,
    input  logic       cfg_aeoi,
    input  logic [7:0] cfg_mask,
    input  logic       cmd_valid,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       busy,
    output logic       init_done,
    output logic       wr_neg,
    output logic       rd_neg,
    output logic       a0,
    output logic [0:7] data_out,
    output logic       data_oe
);

    cfg_t       cfg_q, cfg_d, cfg_in;
    step_e      step_q, step_d, step_nxt;
    logic       in_seq_q, in_seq_d;
    logic       init_done_q, init_done_d;
    logic       wr_start, wr_idle, wr_done;
    logic [8:0] wr_word;
    logic [7:0] wr_data;

    assign cfg_in = {cfg_single, cfg_level, cfg_ic4, cfg_vector, cfg_cascade, cfg_aeoi, cfg_mask};
    assign step_nxt = next_step(step_q, cfg_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q       <= '0;
            step_q      <= StepIcw1;
            in_seq_q    <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            step_q      <= step_d;
            in_seq_q    <= in_seq_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        cfg_d       = cfg_q;
        step_d      = step_q;
        in_seq_d    = in_seq_q;
        init_done_d = init_done_q;
        wr_start    = 1'b0;
        wr_word     = '0;
        if (wr_idle && cfg_start) begin
            // ICW1 comes straight from the inputs so it launches on the accept edge.
            cfg_d       = cfg_in;
            step_d      = StepIcw1;
            in_seq_d    = 1'b1;
            init_done_d = 1'b0;
            wr_start    = 1'b1;
            wr_word     = init_word(StepIcw1, cfg_in);
        end else if (cmd_ready && cmd_valid) begin
            wr_start = 1'b1;
            wr_word  = {cmd_a0, cmd_data};
        end else if (wr_done && in_seq_q) begin
            if (step_q == StepOcw1) begin
                in_seq_d    = 1'b0;
                init_done_d = 1'b1;
            end else begin
                step_d   = step_nxt;
                wr_start = 1'b1;
                wr_word  = init_word(step_nxt, cfg_q);
            end
        end
    end

    pic_bus_writer #(
        .WR_LOW (WR_LOW),
        .WR_GAP (WR_GAP)
    ) u_bus_writer (
        .clk       (clk),
        .rst       (rst),
        .start_i   (wr_start),
        .a0_i      (wr_word[8]),
        .data_i    (wr_word[7:0]),
        .idle_o    (wr_idle),
        .done_o    (wr_done),
        .wr_neg_o  (wr_neg),
        .a0_o      (a0),
        .data_o    (wr_data),
        .data_oe_o (data_oe)
    );

    // data_out is declared [0:7], so bit 0 carries D7.
    assign data_out  = wr_data;
    assign rd_neg    = 1'b1;
    assign busy      = !wr_idle;
    assign init_done = init_done_q;
    assign cmd_ready = wr_idle && init_done_q && !cfg_start;

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Directed bench for pic_init_sequencer: init sequences, runtime write, reset abort
// and start/command collisions, with writes logged from the bus strobes.
module tb_pic_init_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_start = 1'b0;
    logic       cfg_single = 1'b0;
    logic       cfg_level = 1'b0;
    logic       cfg_ic4 = 1'b0;
    logic [4:0] cfg_vector = '0;
    logic [7:0] cfg_cascade = '0;
    logic       cfg_aeoi = 1'b0;
    logic [7:0] cfg_mask = '0;
    logic       cmd_valid = 1'b0;
    logic       cmd_a0 = 1'b0;
    logic [7:0] cmd_data = '0;
    logic       cmd_ready, busy, init_done, wr_neg, rd_neg, a0, data_oe;
    logic [0:7] data_out;
    logic [7:0] data_byte;

    int checks = 0;
    int failures = 0;

    logic [8:0] wlog [0:63];
    int         wr_count = 0;
    int         low_len = 0;
    int         last_low = 0;
    logic       prev_wr = 1'b1;

    pic_init_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_start   (cfg_start),
        .cfg_single  (cfg_single),
        .cfg_level   (cfg_level),
        .cfg_ic4     (cfg_ic4),
        .cfg_vector  (cfg_vector),
        .cfg_cascade (cfg_cascade),
        .cfg_aeoi    (cfg_aeoi),
        .cfg_mask    (cfg_mask),
        .cmd_valid   (cmd_valid),
        .cmd_a0      (cmd_a0),
        .cmd_data    (cmd_data),
        .cmd_ready   (cmd_ready),
        .busy        (busy),
        .init_done   (init_done),
        .wr_neg      (wr_neg),
        .rd_neg      (rd_neg),
        .a0          (a0),
        .data_out    (data_out),
        .data_oe     (data_oe)
    );

    always #5 clk = ~clk;

    assign data_byte = data_out;

    // Log each write at the falling edge of wr_neg and track the low-pulse width.
    always @(negedge clk) begin
        if (wr_neg === 1'b0) begin
            if (prev_wr === 1'b1) begin
                if (wr_count < 64) wlog[wr_count] = {a0, data_byte};
                wr_count = wr_count + 1;
                low_len = 1;
            end else begin
                low_len = low_len + 1;
            end
        end else if (prev_wr === 1'b0) begin
            last_low = low_len;
        end
        prev_wr = wr_neg;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_init(input logic sgl, input logic lvl, input logic ic4,
                            input logic [4:0] vec, input logic [7:0] casc,
                            input logic aeoi, input logic [7:0] mask,
                            output int cycles, output logic busy1, output logic done1);
        cfg_single  = sgl;
        cfg_level   = lvl;
        cfg_ic4     = ic4;
        cfg_vector  = vec;
        cfg_cascade = casc;
        cfg_aeoi    = aeoi;
        cfg_mask    = mask;
        cfg_start   = 1'b1;
        @(negedge clk);
        cfg_start   = 1'b0;
        cfg_single  = ~sgl;
        cfg_level   = ~lvl;
        cfg_ic4     = ~ic4;
        cfg_vector  = ~vec;
        cfg_cascade = ~casc;
        cfg_aeoi    = ~aeoi;
        cfg_mask    = ~mask;
        busy1 = busy;
        done1 = init_done;
        cycles = 0;
        while (init_done !== 1'b1 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (wr_neg !== 1'b1) begin failures++; $display("FAIL reset_wr_neg got=%b want=1", wr_neg); end
        checks++; if (rd_neg !== 1'b1) begin failures++; $display("FAIL reset_rd_neg got=%b want=1", rd_neg); end
        checks++; if (a0 !== 1'b0) begin failures++; $display("FAIL reset_a0 got=%b want=0", a0); end
        checks++; if (data_byte !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", data_byte); end
        checks++; if (data_oe !== 1'b0) begin failures++; $display("FAIL reset_data_oe got=%b want=0", data_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b want=0", init_done); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b want=0", cmd_ready); end
    endtask

    task automatic test_full_init();
        logic [8:0] exp [0:4];
        int base, cyc;
        logic b1, d1;
        exp = '{9'h011, 9'h140, 9'h104, 9'h103, 9'h1FB};
        base = wr_count;
        run_init(1'b0, 1'b0, 1'b1, 5'b01000, 8'h04, 1'b1, 8'hFB, cyc, b1, d1);
        checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL full_busy_after_start got=%b want=1", b1); end
        checks++; if (d1 !== 1'b0) begin failures++; $display("FAIL full_done_after_start got=%b want=0", d1); end
        checks++; if (cyc != 30) begin failures++; $display("FAIL full_cycles got=%0d want=30", cyc); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy_at_done got=%b want=0", busy); end
        checks++; if (wr_count - base != 5) begin failures++; $display("FAIL full_write_count got=%0d want=5", wr_count - base); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (wlog[base + i] !== exp[i]) begin
                failures++;
                $display("FAIL full_word%0d got=%h want=%h", i, wlog[base + i], exp[i]);
            end
        end
    endtask

    task automatic test_single_no_ic4();
        logic [8:0] exp [0:2];
        int base, cyc;
        logic b1, d1;
        exp = '{9'h012, 9'h1A8, 9'h15A};
        base = wr_count;
        run_init(1'b1, 1'b0, 1'b0, 5'b10101, 8'h99, 1'b1, 8'h5A, cyc, b1, d1);
        checks++; if (d1 !== 1'b0) begin failures++; $display("FAIL single_done_cleared got=%b want=0", d1); end
        checks++; if (cyc != 18) begin failures++; $display("FAIL single_cycles got=%0d want=18", cyc); end
        checks++; if (wr_count - base != 3) begin failures++; $display("FAIL single_write_count got=%0d want=3", wr_count - base); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wlog[base + i] !== exp[i]) begin
                failures++;
                $display("FAIL single_word%0d got=%h want=%h", i, wlog[base + i], exp[i]);
            end
        end
    endtask

    task automatic test_cmd_write();
        int base, n;
        base = wr_count;
        cmd_valid = 1'b1;
        cmd_a0    = 1'b0;
        cmd_data  = 8'h20;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL cmd_ready_idle got=%b want=1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL cmd_busy got=%b want=1", busy); end
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != 6) begin failures++; $display("FAIL cmd_ready_low_cycles got=%0d want=6", n); end
        checks++; if (wr_count - base != 1) begin failures++; $display("FAIL cmd_write_count got=%0d want=1", wr_count - base); end
        checks++; if (wlog[base] !== 9'h020) begin failures++; $display("FAIL cmd_word got=%h want=020", wlog[base]); end
        checks++; if (last_low != 2) begin failures++; $display("FAIL cmd_wr_low_width got=%0d want=2", last_low); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cmd_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid_write();
        int base, cyc, k, f;
        logic b1, d1, prev;
        cfg_single = 1'b0; cfg_level = 1'b0; cfg_ic4 = 1'b1; cfg_vector = 5'b01000;
        cfg_cascade = 8'h04; cfg_aeoi = 1'b1; cfg_mask = 8'hFB;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        prev = wr_neg;
        f = 0;
        k = 0;
        while (f < 2 && k < 100) begin
            @(negedge clk);
            k++;
            if (wr_neg === 1'b0 && prev === 1'b1) f++;
            prev = wr_neg;
        end
        checks++; if (f != 2) begin failures++; $display("FAIL abort_find_icw2 got=%0d want=2", f); end
        checks++; if (data_byte !== 8'h40) begin failures++; $display("FAIL abort_in_icw2 got=%h want=40", data_byte); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (wr_neg !== 1'b1) begin failures++; $display("FAIL abort_wr_neg got=%b want=1", wr_neg); end
        checks++; if (data_oe !== 1'b0) begin failures++; $display("FAIL abort_data_oe got=%b want=0", data_oe); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL abort_init_done got=%b want=0", init_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", busy); end
        rst = 1'b0;
        @(negedge clk);
        base = wr_count;
        run_init(1'b0, 1'b0, 1'b1, 5'b01000, 8'h04, 1'b1, 8'hFB, cyc, b1, d1);
        checks++; if (cyc != 30) begin failures++; $display("FAIL replay_cycles got=%0d want=30", cyc); end
        checks++; if (wr_count - base != 5) begin failures++; $display("FAIL replay_count got=%0d want=5", wr_count - base); end
        checks++; if (wlog[base] !== 9'h011) begin failures++; $display("FAIL replay_first_word got=%h want=011", wlog[base]); end
    endtask

    task automatic test_start_while_busy();
        logic [8:0] exp [0:4];
        int base, n;
        exp = '{9'h011, 9'h140, 9'h104, 9'h103, 9'h1FB};
        base = wr_count;
        cfg_single = 1'b0; cfg_level = 1'b0; cfg_ic4 = 1'b1; cfg_vector = 5'b01000;
        cfg_cascade = 8'h04; cfg_aeoi = 1'b1; cfg_mask = 8'hFB;
        cfg_start = 1'b1;
        cmd_valid = 1'b1;
        cmd_a0    = 1'b0;
        cmd_data  = 8'h77;
        #1;
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL collide_cmd_ready got=%b want=0", cmd_ready); end
        @(negedge clk);
        cfg_start  = 1'b0;
        cmd_valid  = 1'b0;
        cfg_single = 1'b1;
        cfg_ic4    = 1'b0;
        cfg_vector = 5'b11111;
        n = 0;
        while (init_done !== 1'b1 && n < 200) begin
            cfg_start = (n == 3 || n == 11 || n == 23);
            @(negedge clk);
            n++;
        end
        cfg_start = 1'b0;
        checks++; if (n != 30) begin failures++; $display("FAIL collide_cycles got=%0d want=30", n); end
        checks++; if (wr_count - base != 5) begin failures++; $display("FAIL collide_count got=%0d want=5", wr_count - base); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (wlog[base + i] !== exp[i]) begin
                failures++;
                $display("FAIL collide_word%0d got=%h want=%h", i, wlog[base + i], exp[i]);
            end
        end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL collide_idle_after got=%b want=0", busy); end
        checks++; if (wr_count - base != 5) begin failures++; $display("FAIL collide_no_cmd got=%0d want=5", wr_count - base); end
    endtask

    initial begin
        test_reset();
        test_full_init();
        test_single_no_ic4();
        test_cmd_write();
        test_reset_mid_write();
        test_start_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
